instr_fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the control unit's decoder. It sequences a program counter, issues word reads to instruction memory over a req/ack handshake, and buffers returned instructions with their PCs in a small prefetch FIFO. The FIFO is presented to the decode/execute stage over a valid/ready interface. Branch and jump redirects from downstream flush the FIFO, squash any in-flight read, and restart fetch at the target.

---
 rtl/instr_fetch_unit.sv | 115 +++++++++++
 tb/tb_instr_fetch_unit.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC sequencing, single-outstanding imem req/ack reads,
// and a small prefetch FIFO presented to decode over valid/ready.
module instr_fetch_unit #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  output logic [15:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DISCARD} state_e;

  state_e            state_q;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] pc_q;
  logic [15:0]       data_q [DEPTH];
  logic [ADDR_W-1:0] tag_q  [DEPTH];
  logic [PW-1:0]     rd_q, wr_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ack, pop, push, room;

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr_valid = (cnt_q != '0);
  assign instr       = data_q[rd_q];
  assign instr_pc    = tag_q[rd_q];

  // Occupancy after this edge decides whether the next request may be issued,
  // so a slot is always guaranteed by the time its ack arrives.
  always_comb begin
    ack   = req_q && imem_ack;
    pop   = instr_valid && instr_ready;
    push  = ack && (state_q == BUSY) && !redirect;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    room  = cnt_d < CW'(DEPTH);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      pc_q    <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else if (redirect) begin
      cnt_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      pc_q  <= redirect_pc;
      // An unacked read cannot be withdrawn: hold it and drop its data later.
      if (state_q != IDLE && !ack) begin
        state_q <= DISCARD;
      end else begin
        state_q <= BUSY;
        req_q   <= 1'b1;
        addr_q  <= redirect_pc;
      end
    end else begin
      cnt_q <= cnt_d;
      if (push) begin
        data_q[wr_q] <= imem_rdata;
        tag_q[wr_q]  <= addr_q;
        wr_q         <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      unique case (state_q)
        IDLE: begin
          if (room) begin
            req_q   <= 1'b1;
            addr_q  <= pc_q;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (ack) begin
            pc_q   <= pc_q + 1'b1;
            addr_q <= pc_q + 1'b1;
            if (!room) begin
              req_q   <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        DISCARD: begin
          if (ack) begin
            addr_q  <= pc_q;
            state_q <= BUSY;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: program-order reference stream,
// latency-configurable memory model, and protocol/hold monitors.
module tb_instr_fetch_unit;
  localparam int AW    = 5;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack = 1'b0;
  logic [15:0]   imem_rdata = 16'hDEAD;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          instr_valid;
  logic [15:0]   instr;
  logic [AW-1:0] instr_pc;
  logic          instr_ready = 1'b0;

  int total = 0;
  int bad = 0;
  int acc_cnt = 0;
  int a0;

  logic [15:0] memw [32];
  logic [20:0] expq [$];
  logic [20:0] e;

  int lat_cur = 0;
  int fixed_lat = 0;
  int wcnt = 0;
  bit rand_lat = 0;

  instr_fetch_unit #(.ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: after reset/redirect the consumer sees memw[start], memw[start+1], ... in order.
  task automatic sb_restart(input int start);
    expq.delete();
    for (int k = 0; k < 2048; k++) begin
      int idx;
      idx = (start + k) % 32;
      expq.push_back({memw[idx], AW'(idx)});
    end
  endtask

  task automatic set_lat(input int l);
    rand_lat  = 0;
    fixed_lat = l;
    lat_cur   = l;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset(input bit rnd_mem);
    reset    = 1'b0;
    redirect = 1'b0;
    #1;
    if (rnd_mem) for (int i = 0; i < 32; i++) memw[i] = 16'($urandom);
    sb_restart(0);
    cyc(3);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", instr_pc, 0);
    reset = 1'b1;
  endtask

  // Memory: acks after lat_cur wait cycles of a held request.
  always @(posedge clk) begin
    #1;
    if (imem_req && reset) begin
      if (wcnt >= lat_cur) begin
        imem_ack   = 1'b1;
        imem_rdata = memw[imem_addr];
        wcnt       = 0;
        lat_cur    = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 16'hDEAD;
        wcnt++;
      end
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 16'hDEAD;
      wcnt       = 0;
    end
  end

  bit            pend = 0, hold = 0, prev_redir = 0;
  logic [AW-1:0] p_addr, h_pc;
  logic [15:0]   h_instr;

  always @(negedge clk) begin
    if (!reset) begin
      pend = 0;
      hold = 0;
      prev_redir = 0;
    end else begin
      if (pend) begin
        chk("req_held", imem_req, 1);
        chk("addr_stable", imem_addr, p_addr);
      end
      if (hold && !prev_redir) begin
        chk("hold_valid", instr_valid, 1);
        chk("hold_instr", instr, h_instr);
        chk("hold_pc", instr_pc, h_pc);
      end
      if (instr_valid && instr_ready) begin
        acc_cnt++;
        if (expq.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          e = expq.pop_front();
          chk("out_pc", instr_pc, e[4:0]);
          chk("out_instr", instr, e[20:5]);
        end
      end
      pend       = imem_req && !imem_ack;
      p_addr     = imem_addr;
      hold       = instr_valid && !instr_ready;
      h_instr    = instr;
      h_pc       = instr_pc;
      prev_redir = redirect;
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) memw[i] = 16'hA000 + 16'(i);

    // Zero-wait streaming with wrap.
    instr_ready = 1'b1;
    set_lat(0);
    do_reset(0);
    cyc(1);
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 0);
    cyc(1);
    chk("ack_to_valid", instr_valid, 1);
    chk("first_pc", instr_pc, 0);
    chk("first_instr", instr, 16'hA000);
    a0 = acc_cnt;
    cyc(40);
    chk("throughput", acc_cnt - a0, 40);

    // Stalled consumer fills exactly DEPTH entries.
    instr_ready = 1'b0;
    do_reset(0);
    cyc(12);
    chk("full_req_low", imem_req, 0);
    chk("full_valid", instr_valid, 1);
    chk("full_pc", instr_pc, 0);
    chk("full_instr", instr, 16'hA000);
    instr_ready = 1'b1;
    cyc(1);
    instr_ready = 1'b0;
    chk("refill_req", imem_req, 1);
    chk("refill_addr", imem_addr, 4);
    chk("after_pop_pc", instr_pc, 1);
    cyc(3);
    chk("refull_req_low", imem_req, 0);

    // Slow memory.
    set_lat(3);
    instr_ready = 1'b1;
    a0 = acc_cnt;
    cyc(60);
    chk("slow_progress", (acc_cnt - a0) >= 10, 1);

    // Redirect while a read is outstanding.
    set_lat(2);
    do_reset(0);
    for (int k = 0; k < 100 && !(imem_req && imem_addr == 5 && !imem_ack); k++) cyc(1);
    chk("wait_pc5", imem_req && imem_addr == 5 && !imem_ack, 1);
    redirect = 1'b1;
    redirect_pc = 5'd20;
    @(posedge clk);
    sb_restart(20);
    #2;
    redirect = 1'b0;
    chk("flush_valid", instr_valid, 0);
    chk("stale_req", imem_req, 1);
    chk("stale_addr", imem_addr, 5);
    for (int k = 0; k < 20 && !imem_ack; k++) cyc(1);
    chk("stale_ack", imem_ack, 1);
    cyc(1);
    chk("target_req", imem_req, 1);
    chk("target_addr", imem_addr, 20);
    cyc(12);

    // Redirect coincident with an ack and a pop.
    set_lat(0);
    instr_ready = 1'b1;
    do_reset(0);
    for (int k = 0; k < 50 && !(imem_req && imem_addr == 3 && imem_ack && instr_valid); k++) cyc(1);
    chk("wait_pc3_ack", imem_req && imem_addr == 3 && imem_ack && instr_valid, 1);
    redirect = 1'b1;
    redirect_pc = 5'd9;
    @(posedge clk);
    sb_restart(9);
    #2;
    redirect = 1'b0;
    chk("r9_flush", instr_valid, 0);
    chk("r9_req", imem_req, 1);
    chk("r9_addr", imem_addr, 9);
    cyc(1);
    chk("r9_valid", instr_valid, 1);
    chk("r9_pc", instr_pc, 9);
    chk("r9_instr", instr, memw[9]);
    cyc(6);

    // Reset mid-request with two entries held.
    instr_ready = 1'b0;
    do_reset(0);
    for (int k = 0; k < 20 && !instr_valid; k++) cyc(1);
    cyc(1);
    chk("mid_req_busy", imem_req, 1);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_req", imem_req, 0);
    chk("mid_rst_valid", instr_valid, 0);
    chk("mid_rst_instr", instr, 0);
    chk("mid_rst_pc", instr_pc, 0);
    instr_ready = 1'b1;
    do_reset(0);
    cyc(1);
    chk("restart_req", imem_req, 1);
    chk("restart_addr", imem_addr, 0);
    cyc(8);

    // Randomized traffic: random latency, backpressure, redirects, memory contents.
    rand_lat = 1;
    lat_cur  = int'($urandom_range(0, 3));
    instr_ready = 1'b1;
    do_reset(1);
    a0 = acc_cnt;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      if (redirect) sb_restart(int'(redirect_pc));
      #2;
      redirect    = ($urandom_range(0, 24) == 0);
      redirect_pc = AW'($urandom);
      instr_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk);
    if (redirect) sb_restart(int'(redirect_pc));
    #2;
    redirect = 1'b0;
    instr_ready = 1'b1;
    cyc(40);
    chk("random_progress", (acc_cnt - a0) > 200, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
